// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Control unit for the multicycle RV32I core. One shared instruction/data
// memory is sequenced through IorD; every datapath control is a Moore decode
// of the state register. The only exceptions are IRWrite/PCWrite in FETCH,
// which fire only on the cycle in which the instruction fetch completes.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   opcode                Instr[6:0] from the instruction register
//   zero                  ALU zero flag (consumed by the datapath through
//                         PCWriteCond, not by this FSM)
//   mem_ready             memory access completes this cycle
//   mem_req .. MemtoReg   datapath controls
//   halted, illegal       HALT indication; illegal is sticky for unknown opcodes
//   state                 current state code, for debug
//   instret, cycles       retired-instruction count and non-halted cycle count
// -----------------------------------------------------------------------------
module controle_multiciclo #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int CNT_W         = 32,
    parameter int STATE_W       = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               RegWrite,
    output logic [1:0]         MemtoReg,
    output logic               halted,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instret,
    output logic [CNT_W-1:0]   cycles
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_LUI    = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic [CNT_W-1:0] r_cycles;

    logic w_mem_done;
    logic w_retire;
    logic w_unused_zero;

    // The branch decision is made in the datapath (PCWriteCond & zero).
    assign w_unused_zero = zero;

    // Without the handshake every access is single-cycle and mem_ready is moot.
    assign w_mem_done = !MEM_HANDSHAKE || mem_ready;

    // An instruction retires on the edge that leaves its last state for FETCH.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI: w_retire = 1'b1;
            S_MEMWR: w_retire = w_mem_done;
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_instret <= '0;
            r_cycles  <= '0;
        end else begin
            if (r_state != S_HALT) r_cycles  <= r_cycles + CNT_W'(1);
            if (w_retire)          r_instret <= r_instret + CNT_W'(1);

            case (r_state)
                S_FETCH:  if (w_mem_done) r_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXECR;
                        OP_ITYPE:          r_state <= S_EXECI;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        OP_JAL:            r_state <= S_JAL;
                        OP_JALR:           r_state <= S_JALR;
                        OP_LUI:            r_state <= S_LUI;
                        OP_SYSTEM:         r_state <= S_HALT;
                        default: begin
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (w_mem_done) r_state <= S_MEMWB;
                S_MEMWR:  if (w_mem_done) r_state <= S_FETCH;
                S_EXECR, S_EXECI: r_state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI: r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode. Gating with reset makes an asserted reset drop the memory
    // request immediately, even though the reset state (FETCH) requests memory.
    always_comb begin
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        RegWrite    = 1'b0;
        MemtoReg    = 2'd0;
        halted      = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcA = 2'd2;
                    ALUSrcB = 2'd1;
                    IRWrite = w_mem_done;
                    PCWrite = w_mem_done;
                end
                S_DECODE: ALUSrcB = 2'd2;
                S_MEMADR: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = 2'd1;
                    ALUOp   = 2'd2;
                end
                S_EXECI: begin
                    ALUSrcA = 2'd1;
                    ALUSrcB = 2'd2;
                    ALUOp   = 2'd2;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 2'd1;
                    ALUOp       = 2'd1;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                end
                S_JAL: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd2;
                    PCWrite  = 1'b1;
                    PCSource = 2'd1;
                end
                S_JALR: begin
                    ALUSrcA  = 2'd1;
                    ALUSrcB  = 2'd2;
                    RegWrite = 1'b1;
                    MemtoReg = 2'd2;
                    PCWrite  = 1'b1;
                end
                S_LUI: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd3;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign state   = STATE_W'(r_state);
    assign instret = r_instret;
    assign cycles  = r_cycles;

endmodule
